scan_select_gen: RTL and testbench

Registered slot-select sequencer that sits directly upstream of the 3-to-8 decoder and drives its 3-bit `in`. It steps a select index through eight slots, holds each enabled slot for a programmable dwell, skips masked slots, and runs in either direction. Typical uses are LED/keypad row scanning and time-multiplexed enables, with the decoder's one-hot output as the strobe.

---
 rtl/scan_pkg.sv | 32 +++
 rtl/scan_next_slot.sv | 58 +++++
 rtl/scan_select_gen.sv | 113 +++++++++++
 tb/tb_scan_select_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the slot-select sequencer.
//   SLOTS / SEL_W : number of slots and width of a slot index
//   state_e       : sequencer state (IDLE, RUN)
//   DIR_UP/DIR_DN : values of the direction input
//   step_idx      : circular index step (base +/- offset, modulo SLOTS)
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int SLOTS = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Offsets are taken modulo SLOTS by truncation to SEL_W bits, so an offset of
  // SLOTS lands back on the base index.
  function automatic logic [SEL_W-1:0] step_idx(input logic [SEL_W-1:0] base,
                                                input logic [SEL_W:0]   off,
                                                input logic             dir);
    logic [SEL_W-1:0] w_off;
    w_off = off[SEL_W-1:0];
    return (dir == DIR_UP) ? (base + w_off) : (base - w_off);
  endfunction

endpackage

// File: rtl/scan_next_slot.sv
// -----------------------------------------------------------------------------
// scan_next_slot
// Combinational circular priority search over the slot mask.
//   i_mask      : slot enables, bit i enables slot i
//   i_start     : index the search is anchored at
//   i_dir       : DIR_UP searches upward, DIR_DN downward (circular)
//   i_inclusive : 1 = i_start itself is the first candidate (first-slot search)
//                 0 = first candidate is one past i_start (next-slot search);
//                     i_start itself is then the last candidate
//   o_next      : first enabled slot found
//   o_found     : at least one slot is enabled
//   o_wrapped   : next-slot search crossed the end of the index range
// -----------------------------------------------------------------------------
module scan_next_slot
  import scan_pkg::*;
(
  input  logic [SLOTS-1:0] i_mask,
  input  logic [SEL_W-1:0] i_start,
  input  logic             i_dir,
  input  logic             i_inclusive,
  output logic [SEL_W-1:0] o_next,
  output logic             o_found,
  output logic             o_wrapped
);

  logic [SEL_W-1:0] w_cand [SLOTS];
  logic [SLOTS-1:0] w_hit;

  // Candidate gi is the slot gi steps away (plus one for a next-slot search).
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_cand
    logic [SEL_W:0] w_off;
    assign w_off     = (SEL_W+1)'(gi) + {{SEL_W{1'b0}}, ~i_inclusive};
    assign w_cand[gi] = step_idx(i_start, w_off, i_dir);
    assign w_hit[gi]  = i_mask[w_cand[gi]];
  end

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    o_next  = i_start;
    o_found = 1'b0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_next  = w_cand[k];
        o_found = 1'b1;
      end
    end
  end

  // A circular step lands at or below the anchor (upward) or at or above it
  // (downward) exactly when it wrapped; a lone slot re-selecting itself counts.
  always_comb begin
    o_wrapped = 1'b0;
    if (o_found && !i_inclusive) begin
      o_wrapped = (i_dir == DIR_UP) ? (o_next <= i_start) : (o_next >= i_start);
    end
  end

endmodule

// File: rtl/scan_select_gen.sv
// -----------------------------------------------------------------------------
// scan_select_gen
// Registered slot-select sequencer feeding a 3-to-8 decoder. Steps a slot index
// through the enabled slots, holding each for i_dwell+1 cycles.
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_en        : run request (level)
//   i_dir       : 0 ascending, 1 descending
//   i_mask      : slot enables
//   i_dwell     : cycles per slot minus one, sampled live
//   o_sel       : current slot index
//   o_sel_valid : o_sel is an active, enabled slot
//   o_wrap      : one-cycle pulse when the sequence wraps
// -----------------------------------------------------------------------------
module scan_select_gen
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_dir,
  input  logic [SLOTS-1:0]   i_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_sel_valid,
  output logic               o_wrap
);

  state_e             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_sel_valid;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;

  logic [SEL_W-1:0]   w_start;
  logic               w_inclusive;
  logic [SEL_W-1:0]   w_next;
  logic               w_found;
  logic               w_wrapped;
  logic               w_stop;
  logic               w_advance;

  // One search unit serves both states: in IDLE it finds the first enabled
  // slot from the end matching i_dir, in RUN the slot after the current one.
  assign w_inclusive = (r_state == IDLE);
  assign w_start     = (r_state == IDLE) ? ((i_dir == DIR_DN) ? SEL_W'(SLOTS - 1) : '0)
                                         : r_sel;

  scan_next_slot u_next (
    .i_mask      (i_mask),
    .i_start     (w_start),
    .i_dir       (i_dir),
    .i_inclusive (w_inclusive),
    .o_next      (w_next),
    .o_found     (w_found),
    .o_wrapped   (w_wrapped)
  );

  assign w_stop    = !i_en || !w_found;
  // >= lets a shrinking dwell take effect immediately; a disabled current slot
  // forces the advance regardless of the count.
  assign w_advance = (r_cnt >= i_dwell) || !i_mask[r_sel];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_stop) begin
            r_state     <= RUN;
            r_sel       <= w_next;
            r_sel_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_sel_valid <= 1'b0;
          end
        end
        RUN: begin
          // Stopping takes priority over a coincident advance.
          if (w_stop) begin
            r_state     <= IDLE;
            r_sel_valid <= 1'b0;
            r_cnt       <= '0;
          end else if (w_advance) begin
            r_sel  <= w_next;
            r_wrap <= w_wrapped;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sel_valid <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign o_sel       = r_sel;
  assign o_sel_valid = r_sel_valid;
  assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_scan_select_gen.sv
module tb_scan_select_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  scan_select_gen #(.DWELL_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_dir       (dir),
    .i_mask      (mask),
    .i_dwell     (dwell),
    .o_sel       (sel),
    .o_sel_valid (sel_valid),
    .o_wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       dir;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       valid;
    logic       wrap;
  } vec_t;

  vec_t tbl[24];

  // Behavioural reference state
  bit m_run;
  int m_sel;
  int m_cnt;
  bit m_wrap;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic d, input logic [7:0] m,
                              input logic [7:0] dw, input logic [2:0] s,
                              input logic v, input logic w);
    vec_t r;
    r.en = e; r.dir = d; r.mask = m; r.dwell = dw; r.sel = s; r.valid = v; r.wrap = w;
    return r;
  endfunction

  // First enabled slot walking circularly from 'from' in direction d.
  function automatic int find_slot(input logic [7:0] m, input int from,
                                   input logic d, input bit incl);
    int first_off = incl ? 0 : 1;
    for (int off = first_off; off < first_off + 8; off++) begin
      int idx = d ? (from - off) : (from + off);
      idx = ((idx % 8) + 8) % 8;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock edge of the sequencing rules, using the inputs currently driven.
  task automatic model_step();
    m_wrap = 1'b0;
    if (!m_run) begin
      if (en && mask != 8'h00) begin
        m_sel = find_slot(mask, dir ? 7 : 0, dir, 1'b1);
        m_run = 1'b1;
        m_cnt = 0;
      end
    end else if (!en || mask == 8'h00) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (m_cnt >= int'(dwell) || !mask[m_sel]) begin
      int ns = find_slot(mask, m_sel, dir, 1'b0);
      m_wrap = dir ? (ns >= m_sel) : (ns <= m_sel);
      m_sel  = ns;
      m_cnt  = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; mask = 8'h00; dwell = 8'd0;
    @(negedge clk);
    check("reset_sel", int'(sel), 0);
    check("reset_valid", int'(sel_valid), 0);
    check("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; mask = 8'h00; dwell = 8'd0;

    // ---------------- table-driven vectors ----------------
    tbl[0]  = mk(1, 0, 8'hA4, 0, 2, 1, 0);
    tbl[1]  = mk(1, 0, 8'hA4, 0, 5, 1, 0);
    tbl[2]  = mk(1, 0, 8'hA4, 0, 7, 1, 0);
    tbl[3]  = mk(1, 0, 8'hA4, 0, 2, 1, 1);
    tbl[4]  = mk(1, 0, 8'hA4, 0, 5, 1, 0);
    tbl[5]  = mk(1, 0, 8'hA4, 0, 7, 1, 0);
    tbl[6]  = mk(0, 0, 8'hA4, 0, 7, 0, 0);
    tbl[7]  = mk(1, 0, 8'h10, 3, 4, 1, 0);
    tbl[8]  = mk(1, 0, 8'h10, 3, 4, 1, 0);
    tbl[9]  = mk(1, 0, 8'h10, 3, 4, 1, 0);
    tbl[10] = mk(1, 0, 8'h10, 3, 4, 1, 0);
    tbl[11] = mk(1, 0, 8'h10, 3, 4, 1, 1);
    tbl[12] = mk(1, 0, 8'h10, 3, 4, 1, 0);
    tbl[13] = mk(1, 0, 8'h10, 3, 4, 1, 0);
    tbl[14] = mk(1, 0, 8'h10, 3, 4, 1, 0);
    tbl[15] = mk(1, 0, 8'h10, 3, 4, 1, 1);
    tbl[16] = mk(1, 1, 8'hFF, 0, 3, 1, 0);
    tbl[17] = mk(1, 1, 8'hFF, 0, 2, 1, 0);
    tbl[18] = mk(1, 1, 8'hFF, 0, 1, 1, 0);
    tbl[19] = mk(1, 1, 8'hFF, 0, 0, 1, 0);
    tbl[20] = mk(1, 1, 8'hFF, 0, 7, 1, 1);
    tbl[21] = mk(1, 0, 8'hFF, 0, 0, 1, 1);
    tbl[22] = mk(1, 0, 8'hFF, 0, 1, 1, 0);
    tbl[23] = mk(1, 0, 8'h00, 0, 1, 0, 0);

    do_reset();
    for (int i = 0; i < 24; i++) begin
      en = tbl[i].en; dir = tbl[i].dir; mask = tbl[i].mask; dwell = tbl[i].dwell;
      @(negedge clk);
      $display("vec %0d: en=%0b dir=%0b mask=%02h dwell=%0d -> sel=%0d valid=%0b wrap=%0b",
               i, en, dir, mask, dwell, sel, sel_valid, wrap);
      check($sformatf("vec%0d_sel", i), int'(sel), int'(tbl[i].sel));
      check($sformatf("vec%0d_valid", i), int'(sel_valid), int'(tbl[i].valid));
      check($sformatf("vec%0d_wrap", i), int'(wrap), int'(tbl[i].wrap));
    end

    // ---------------- full sweep, dwell=1 ----------------
    do_reset();
    en = 1; dir = 0; mask = 8'hFF; dwell = 8'd1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      $display("sweep %0d: sel=%0d valid=%0b wrap=%0b", k, sel, sel_valid, wrap);
      check($sformatf("sweep%0d_sel", k), int'(sel), (k / 2) % 8);
      check($sformatf("sweep%0d_valid", k), int'(sel_valid), 1);
      check($sformatf("sweep%0d_wrap", k), int'(wrap), (k == 16) ? 1 : 0);
    end

    // ---------------- forced advance, then mask=0 ----------------
    do_reset();
    en = 1; dir = 0; mask = 8'hFF; dwell = 8'd9;
    repeat (3) @(negedge clk);   // entry edge, then count reaches 2
    check("forced_pre_sel", int'(sel), 0);
    mask = 8'hFE;
    @(negedge clk);
    $display("forced: sel=%0d valid=%0b wrap=%0b", sel, sel_valid, wrap);
    check("forced_sel", int'(sel), 1);
    check("forced_wrap", int'(wrap), 0);
    check("forced_valid", int'(sel_valid), 1);
    mask = 8'h00;
    @(negedge clk);
    check("maskzero_valid", int'(sel_valid), 0);
    check("maskzero_sel", int'(sel), 1);

    // ---------------- en drop on an advance cycle ----------------
    en = 1; mask = 8'hFF; dwell = 8'd0;
    @(negedge clk);
    check("drop_entry_sel", int'(sel), 0);
    @(negedge clk);
    check("drop_adv_sel", int'(sel), 1);
    en = 0;
    @(negedge clk);
    $display("en drop: sel=%0d valid=%0b wrap=%0b", sel, sel_valid, wrap);
    check("drop_sel", int'(sel), 1);
    check("drop_valid", int'(sel_valid), 0);
    check("drop_wrap", int'(wrap), 0);

    // ---------------- asynchronous reset mid-dwell ----------------
    en = 1; dir = 1; mask = 8'hFF; dwell = 8'd5;
    @(negedge clk);
    check("async_pre_sel", int'(sel), 7);
    check("async_pre_valid", int'(sel_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: sel=%0d valid=%0b wrap=%0b", sel, sel_valid, wrap);
    check("async_sel", int'(sel), 0);
    check("async_valid", int'(sel_valid), 0);
    check("async_wrap", int'(wrap), 0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_run = 0; m_sel = 0; m_cnt = 0; m_wrap = 0;
    mask = 8'hFF; dwell = 8'd2;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 4))
          0: mask = 8'h01 << $urandom_range(0, 7);
          1: mask = 8'hFF;
          2: mask = 8'h00;
          default: mask = 8'($urandom);
        endcase
      end
      if (m_run && $urandom_range(0, 19) == 0) mask[m_sel] = 1'b0;
      model_step();
      @(negedge clk);
      check($sformatf("rand%0d_sel", i), int'(sel), m_sel);
      check($sformatf("rand%0d_valid", i), int'(sel_valid), int'(m_run));
      check($sformatf("rand%0d_wrap", i), int'(wrap), int'(m_wrap));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
